dmem: RTL and testbench
=======================

Name: dmem

Overview:
- Data-side memory responder that answers the execute stage's load/store request interface.
- Single-port, word-organised scratchpad.
- Loads return data combinationally in the request cycle; stores commit on the next rising clock edge with byte-lane masking.
- Reports misaligned and out-of-range accesses as registered one-cycle error pulses, and keeps load/store performance counters.

Parameters:
- XLEN, riscv::XLEN (32): data/address width.
- DEPTH, 1024: number of XLEN-bit words.
- BASE_ADR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- INIT_FILE, "": hex image loaded into the array at elaboration when non-empty.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- adr_v_i  in  1  request valid
- adr_i  in  XLEN  byte address
- is_store_i  in  1  1 = store, 0 = load; qualified by adr_v_i
- store_data_i  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
- access_size_i  in  3  riscv::SIZE_B / SIZE_H / SIZE_W
- load_data_o  out  XLEN  addressed word shifted right by 8*adr_i[1:0]
- err_v_q_o  out  1  registered error pulse
- err_cause_q_o  out  2  riscv::MEM_ERR_MISAL / MEM_ERR_RANGE
- err_adr_q_o  out  XLEN  faulting address
- ld_cnt_q_o  out  32  completed loads
- st_cnt_q_o  out  32  completed stores

Behaviour:
- Clock and reset: one clock (clk); reset_n asynchronous, active-low.
- Reset values:
  - err_v_q_o=0, err_cause_q_o=0, err_adr_q_o=0, ld_cnt_q_o=0, st_cnt_q_o=0.
  - Memory array is not reset; it keeps its contents, or the INIT_FILE image after elaboration.
  - load_data_o is combinational and therefore has no reset value.
- Index and range: idx = (adr_i - BASE_ADR) >> 2. in_range = adr_i >= BASE_ADR && idx < DEPTH, computed at full width with no wrap. A BASE_ADR + 4*DEPTH overflow is disallowed by parameter check.
- Misalignment:
  - SIZE_H with adr_i[0]=1, or SIZE_W with adr_i[1:0]!=0, is misaligned.
  - Any other access_size_i encoding is treated as misaligned.
- Fault: fault = adr_v_i & (misaligned | !in_range). Misaligned takes priority over range for the cause.
- Load, same cycle, no latency:
  - Valid: load_data_o = mem[idx] >> (8*adr_i[1:0]); upper bits are zero-filled. The LSU performs size masking and sign extension.
  - Faulting load or adr_v_i=0: load_data_o = 0.
- Store, commits at the next posedge:
  - Valid, non-faulting: lane mask = {SIZE_B:4'b0001, SIZE_H:4'b0011, SIZE_W:4'b1111} << adr_i[1:0]; data = store_data_i << (8*adr_i[1:0]).
  - Only masked bytes of mem[idx] change. A faulting store writes nothing.
- Read-after-write:
  - A load in cycle N+1 to a location stored in cycle N returns the new data.
  - A load and a store cannot be presented in the same cycle (single request).
- Errors:
  - err_v_q_o asserts for exactly one cycle after a faulting request, with cause and address captured.
  - On back-to-back faults it stays high and the captured values update every cycle.
  - err_cause_q_o and err_adr_q_o hold their last values when err_v_q_o=0.
- Counters:
  - ld_cnt_q_o increments on each valid non-faulting load; st_cnt_q_o on each valid non-faulting store.
  - Both wrap from 32'hFFFF_FFFF to 0.
- adr_v_i=0: no write, no counter change, no error.
- Reset asserted mid-operation: registers clear immediately. A store whose edge coincides with reset assertion is not guaranteed to commit; no other guarantee on that edge.

Decomposition:
- Add to the riscv package: SIZE_B=3'b001, SIZE_H=3'b010, SIZE_W=3'b100, MEM_ERR_MISAL=2'd1, MEM_ERR_RANGE=2'd2.
- One sub-module, dmem_lane_dec: combinational; takes (access_size, adr[1:0]) and produces (byte mask[3:0], shift amount, misaligned).
- Counters and error register stay in dmem.

Test Plan:
- Reset check: reset_n low → all registered outputs are 0. Release reset, no requests → counters stay 0.
- Store then load, word: store SIZE_W 0xDEADBEEF to 0x10, then load SIZE_W 0x10 next cycle → load_data_o=0xDEADBEEF, st_cnt=1, ld_cnt=1.
- Byte/half lanes:
  - Store SIZE_B 0x5A to 0x13 → word at 0x10 reads 0x5AADBEEF.
  - Store SIZE_H 0x1234 to 0x12 → word reads 0x1234BEEF.
  - Load SIZE_B at 0x13 → load_data_o=0x00000012.
- Misaligned: store SIZE_W 0x11111111 to 0x11 → memory unchanged, err_v_q_o=1 for one cycle with cause MISAL and adr 0x11, st_cnt unchanged. Load SIZE_H at 0x13 → load_data_o=0, same error behaviour.
- Out of range: with BASE_ADR=0x1000, DEPTH=4, load at 0x1010 and at 0x0FFC → each gives err cause RANGE, load_data_o=0. Load at 0x100C is valid.
- Counter wrap and back-to-back faults: force ld_cnt to 0xFFFFFFFF, do one valid load → 0. Issue two consecutive faulting accesses → err_v_q_o high for two cycles with the second address captured.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg (package)
// Brief    : Lane helpers for the data scratchpad.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int c_num_lanes = 4;

    // Expands a per-byte enable into a per-bit write mask
    function automatic logic [8*c_num_lanes-1:0] lane_bits(input logic [c_num_lanes-1:0] byte_mask);
        logic [8*c_num_lanes-1:0] bits;
        for (int i = 0; i < c_num_lanes; i++) begin
            bits[8*i +: 8] = {8{byte_mask[i]}};
        end
        return bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv.sv
`default_nettype none
// ============================================================================
// Module   : riscv (package)
// Brief    : Core-wide constants shared by the pipeline and memory blocks.
// Revision : 1.0
// ============================================================================
package riscv;

    localparam int XLEN = 32;

    // Access-size encodings carried on the execute-to-memory interface
    localparam logic [2:0] SIZE_B = 3'b001;
    localparam logic [2:0] SIZE_H = 3'b010;
    localparam logic [2:0] SIZE_W = 3'b100;

    localparam logic [1:0] MEM_ERR_MISAL = 2'd1;
    localparam logic [1:0] MEM_ERR_RANGE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_dec.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_dec
// Brief    : Decodes access size and low address bits into lane mask,
//            byte shift and misalignment flag.
// Revision : 1.0
// ============================================================================
module dmem_lane_dec
    import riscv::*;
(
    input  logic [2:0] i_access_size,
    input  logic [1:0] i_adr_lo,
    output logic [3:0] o_byte_mask,
    output logic [4:0] o_shamt,
    output logic       o_misaligned
);

    always_comb begin
        o_byte_mask  = 4'b0000;
        o_misaligned = 1'b1;
        case (i_access_size)
            SIZE_B: begin
                o_byte_mask  = 4'b0001 << i_adr_lo;
                o_misaligned = 1'b0;
            end
            SIZE_H: begin
                o_byte_mask  = 4'b0011 << i_adr_lo;
                o_misaligned = i_adr_lo[0];
            end
            SIZE_W: begin
                o_byte_mask  = 4'b1111;
                o_misaligned = (i_adr_lo != 2'b00);
            end
            default: begin
                // Unknown size encodings are reported as misaligned
                o_byte_mask  = 4'b0000;
                o_misaligned = 1'b1;
            end
        endcase
    end

    assign o_shamt = {i_adr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/dmem.sv
`default_nettype none
// ============================================================================
// Module   : dmem
// Brief    : Single-port data scratchpad with combinational loads, masked
//            stores, registered error pulses and load/store counters.
// Revision : 1.0
// ============================================================================
module dmem
    import dmem_pkg::*;
#(
    parameter int              XLEN      = riscv::XLEN,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADR  = 32'h0000_0000,
    parameter                  INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            err_v_q_o,
    output logic [1:0]      err_cause_q_o,
    output logic [XLEN-1:0] err_adr_q_o,
    output logic [31:0]     ld_cnt_q_o,
    output logic [31:0]     st_cnt_q_o
);

    localparam int c_aw = $clog2(DEPTH);

    if (XLEN != 32 || DEPTH < 2 || BASE_ADR[1:0] != 2'b00 ||
        (64'(BASE_ADR) + 64'(DEPTH) * 64'd4) > 64'h1_0000_0000) begin : g_param_err
        $error("dmem: illegal XLEN/DEPTH/BASE_ADR combination");
    end

    logic [XLEN-1:0] r_mem [DEPTH];

    logic [XLEN-1:0] w_idx_full;
    logic [c_aw-1:0] w_idx;
    logic            w_in_range;
    logic [3:0]      w_byte_mask;
    logic [4:0]      w_shamt;
    logic            w_misal;
    logic            w_fault;
    logic            w_load_ok;
    logic            w_store_ok;
    logic [XLEN-1:0] w_wbits;
    logic [XLEN-1:0] w_wdata;
    logic [1:0]      w_cause;

    logic            r_err_v;
    logic [1:0]      r_err_cause;
    logic [XLEN-1:0] r_err_adr;
    logic [31:0]     r_ld_cnt;
    logic [31:0]     r_st_cnt;

    dmem_lane_dec u_lane_dec (
        .i_access_size (access_size_i),
        .i_adr_lo      (adr_i[1:0]),
        .o_byte_mask   (w_byte_mask),
        .o_shamt       (w_shamt),
        .o_misaligned  (w_misal)
    );

    // Below-base check guards the subtraction, so the full-width index never wraps into range
    assign w_idx_full = (adr_i - BASE_ADR) >> 2;
    assign w_in_range = (adr_i >= BASE_ADR) && (w_idx_full < XLEN'(DEPTH));
    assign w_idx      = w_idx_full[c_aw-1:0];

    assign w_fault    = adr_v_i && (w_misal || !w_in_range);
    assign w_load_ok  = adr_v_i && !is_store_i && !w_fault;
    assign w_store_ok = adr_v_i &&  is_store_i && !w_fault;
    assign w_cause    = w_misal ? riscv::MEM_ERR_MISAL : riscv::MEM_ERR_RANGE;

    assign w_wbits    = lane_bits(w_byte_mask);
    assign w_wdata    = store_data_i << w_shamt;

    assign load_data_o = w_load_ok ? (r_mem[w_idx] >> w_shamt) : '0;

    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wbits) | (w_wdata & w_wbits);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_v     <= 1'b0;
            r_err_cause <= 2'd0;
            r_err_adr   <= '0;
            r_ld_cnt    <= 32'd0;
            r_st_cnt    <= 32'd0;
        end else begin
            r_err_v <= w_fault;
            if (w_fault) begin
                r_err_cause <= w_cause;
                r_err_adr   <= adr_i;
            end
            if (w_load_ok) begin
                r_ld_cnt <= r_ld_cnt + 32'd1;
            end
            if (w_store_ok) begin
                r_st_cnt <= r_st_cnt + 32'd1;
            end
        end
    end

    assign err_v_q_o     = r_err_v;
    assign err_cause_q_o = r_err_cause;
    assign err_adr_q_o   = r_err_adr;
    assign ld_cnt_q_o    = r_ld_cnt;
    assign st_cnt_q_o    = r_st_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem
// Brief    : Self-checking bench for dmem: directed table, small-window
//            range sequence and randomized traffic against a byte model.
// Revision : 1.0
// ============================================================================
module tb_dmem;
    import riscv::*;

    localparam logic [31:0] c_small_base = 32'h0000_1000;
    localparam int          c_big_bytes  = 4096;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        adr_v, is_store;
    logic [31:0] adr, sdata;
    logic [2:0]  size;
    logic [31:0] load_data, err_adr, ld_cnt, st_cnt;
    logic        err_v;
    logic [1:0]  err_cause;

    logic        s_adr_v, s_is_store;
    logic [31:0] s_adr, s_sdata;
    logic [2:0]  s_size;
    logic [31:0] s_load_data, s_err_adr, s_ld_cnt, s_st_cnt;
    logic        s_err_v;
    logic [1:0]  s_err_cause;

    dmem #(.DEPTH(1024), .BASE_ADR(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .adr_v_i(adr_v), .adr_i(adr),
        .is_store_i(is_store), .store_data_i(sdata), .access_size_i(size),
        .load_data_o(load_data), .err_v_q_o(err_v), .err_cause_q_o(err_cause),
        .err_adr_q_o(err_adr), .ld_cnt_q_o(ld_cnt), .st_cnt_q_o(st_cnt)
    );

    dmem #(.DEPTH(4), .BASE_ADR(c_small_base)) dut_s (
        .clk(clk), .reset_n(reset_n), .adr_v_i(s_adr_v), .adr_i(s_adr),
        .is_store_i(s_is_store), .store_data_i(s_sdata), .access_size_i(s_size),
        .load_data_o(s_load_data), .err_v_q_o(s_err_v), .err_cause_q_o(s_err_cause),
        .err_adr_q_o(s_err_adr), .ld_cnt_q_o(s_ld_cnt), .st_cnt_q_o(s_st_cnt)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Byte-addressed reference model of the large instance (base 0)
    logic [7:0]  m_mem [c_big_bytes];
    logic        m_err_v;
    logic [1:0]  m_cause;
    logic [31:0] m_eadr, m_ld, m_st;

    function automatic bit ref_misal(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            SIZE_B:  return 1'b0;
            SIZE_H:  return a[0];
            SIZE_W:  return a[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            SIZE_B:  return 1;
            SIZE_H:  return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_err_v = 1'b0; m_cause = 2'd0; m_eadr = 32'd0; m_ld = 32'd0; m_st = 32'd0;
    endtask

    task automatic model_step(input bit v, input bit st, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] sz,
                              output logic [31:0] exp_load);
        bit mis, inr, flt;
        int b;
        logic [31:0] w;
        mis = ref_misal(sz, a);
        inr = a < 32'(c_big_bytes);
        flt = v && (mis || !inr);
        exp_load = 32'd0;
        m_err_v = flt;
        if (flt) begin
            m_cause = mis ? MEM_ERR_MISAL : MEM_ERR_RANGE;
            m_eadr  = a;
        end
        if (v && !flt) begin
            if (st) begin
                for (int k = 0; k < nbytes(sz); k++) m_mem[int'(a) + k] = d[8*k +: 8];
                m_st = m_st + 32'd1;
            end else begin
                b = int'(a) & ~3;
                w = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
                exp_load = w >> (8 * (int'(a) % 4));
                m_ld = m_ld + 32'd1;
            end
        end
    endtask

    task automatic check_big_regs(input string tag);
        chk({tag, ".err_v"}, {31'd0, err_v}, {31'd0, m_err_v});
        chk({tag, ".cause"}, {30'd0, err_cause}, {30'd0, m_cause});
        chk({tag, ".err_adr"}, err_adr, m_eadr);
        chk({tag, ".ld_cnt"}, ld_cnt, m_ld);
        chk({tag, ".st_cnt"}, st_cnt, m_st);
    endtask

    // One request: inputs driven after an edge, load sampled at negedge, registers after next edge
    task automatic req(input bit which, input bit v, input bit st, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sz, output logic [31:0] got);
        if (!which) begin
            adr_v = v; is_store = st; adr = a; sdata = d; size = sz;
        end else begin
            s_adr_v = v; s_is_store = st; s_adr = a; s_sdata = d; s_size = sz;
        end
        @(negedge clk);
        got = which ? s_load_data : load_data;
        @(posedge clk);
        #1;
        adr_v = 1'b0;
        s_adr_v = 1'b0;
    endtask

    typedef struct {
        bit          v;
        bit          st;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  sz;
        bit          chk_ld;
        logic [31:0] exp_ld;
        bit          exp_err;
        logic [1:0]  exp_cause;
        logic [31:0] exp_eadr;
    } vec_t;

    function automatic vec_t mk(input bit v, input bit st, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] sz, input bit chk_ld,
                                input logic [31:0] exp_ld, input bit exp_err,
                                input logic [1:0] exp_cause, input logic [31:0] exp_eadr);
        vec_t r;
        r.v = v; r.st = st; r.a = a; r.d = d; r.sz = sz; r.chk_ld = chk_ld;
        r.exp_ld = exp_ld; r.exp_err = exp_err; r.exp_cause = exp_cause; r.exp_eadr = exp_eadr;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] got, exp;
        bit          v, st;
        logic [31:0] a, d;
        logic [2:0]  sz;
        int          r;

        reset_n = 1'b0;
        adr_v = 0; is_store = 0; adr = 0; sdata = 0; size = SIZE_W;
        s_adr_v = 0; s_is_store = 0; s_adr = 0; s_sdata = 0; s_size = SIZE_W;
        for (int i = 0; i < c_big_bytes; i++) m_mem[i] = 8'h00;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_big_regs("reset");
        chk("reset.s_err_v", {31'd0, s_err_v}, 32'd0);
        chk("reset.s_cause", {30'd0, s_err_cause}, 32'd0);
        chk("reset.s_err_adr", s_err_adr, 32'd0);
        chk("reset.s_ld_cnt", s_ld_cnt, 32'd0);
        chk("reset.s_st_cnt", s_st_cnt, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_big_regs("idle");
        chk("idle.s_ld_cnt", s_ld_cnt, 32'd0);

        // Directed table on the large instance
        tbl.push_back(mk(1, 1, 32'h10,   32'hDEADBEEF, SIZE_W, 0, 32'h0,        0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 0, 32'h10,   32'h0,        SIZE_W, 1, 32'hDEADBEEF, 0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 1, 32'h13,   32'h5A,       SIZE_B, 0, 32'h0,        0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 0, 32'h10,   32'h0,        SIZE_W, 1, 32'h5AADBEEF, 0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 1, 32'h12,   32'h1234,     SIZE_H, 0, 32'h0,        0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 0, 32'h10,   32'h0,        SIZE_W, 1, 32'h1234BEEF, 0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 0, 32'h13,   32'h0,        SIZE_B, 1, 32'h00000012, 0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 0, 32'h11,   32'h0,        SIZE_B, 1, 32'h001234BE, 0, 2'd0,          32'h0));
        tbl.push_back(mk(1, 1, 32'h11,   32'h11111111, SIZE_W, 0, 32'h0,        1, MEM_ERR_MISAL, 32'h11));
        tbl.push_back(mk(1, 0, 32'h10,   32'h0,        SIZE_W, 1, 32'h1234BEEF, 0, MEM_ERR_MISAL, 32'h11));
        tbl.push_back(mk(1, 0, 32'h13,   32'h0,        SIZE_H, 1, 32'h0,        1, MEM_ERR_MISAL, 32'h13));
        tbl.push_back(mk(1, 0, 32'h12,   32'h0,        SIZE_H, 1, 32'h00001234, 0, MEM_ERR_MISAL, 32'h13));
        tbl.push_back(mk(1, 0, 32'h10,   32'h0,        3'b011, 1, 32'h0,        1, MEM_ERR_MISAL, 32'h10));
        tbl.push_back(mk(1, 0, 32'h4000, 32'h0,        SIZE_W, 1, 32'h0,        1, MEM_ERR_RANGE, 32'h4000));
        tbl.push_back(mk(0, 0, 32'h10,   32'h0,        SIZE_W, 1, 32'h0,        0, MEM_ERR_RANGE, 32'h4000));
        tbl.push_back(mk(1, 1, 32'hFFC,  32'hA5A50F0F, SIZE_W, 0, 32'h0,        0, MEM_ERR_RANGE, 32'h4000));
        tbl.push_back(mk(1, 0, 32'hFFC,  32'h0,        SIZE_W, 1, 32'hA5A50F0F, 0, MEM_ERR_RANGE, 32'h4000));
        tbl.push_back(mk(1, 1, 32'h1000, 32'h77777777, SIZE_W, 0, 32'h0,        1, MEM_ERR_RANGE, 32'h1000));

        foreach (tbl[i]) begin
            req(0, tbl[i].v, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].sz, got);
            model_step(tbl[i].v, tbl[i].st, tbl[i].a, tbl[i].d, tbl[i].sz, exp);
            if (tbl[i].chk_ld) chk($sformatf("tbl%0d.load", i), got, tbl[i].exp_ld);
            chk($sformatf("tbl%0d.err_v", i), {31'd0, err_v}, {31'd0, tbl[i].exp_err});
            chk($sformatf("tbl%0d.cause", i), {30'd0, err_cause}, {30'd0, tbl[i].exp_cause});
            chk($sformatf("tbl%0d.err_adr", i), err_adr, tbl[i].exp_eadr);
            chk($sformatf("tbl%0d.ld_cnt", i), ld_cnt, m_ld);
            chk($sformatf("tbl%0d.st_cnt", i), st_cnt, m_st);
        end

        // Load counter wrap
        force dut.r_ld_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_ld_cnt;
        m_ld = 32'hFFFF_FFFF;
        chk("wrap.preload", ld_cnt, 32'hFFFF_FFFF);
        req(0, 1, 0, 32'h10, 32'h0, SIZE_W, got);
        model_step(1, 0, 32'h10, 32'h0, SIZE_W, exp);
        chk("wrap.load", got, 32'h1234BEEF);
        chk("wrap.ld_cnt", ld_cnt, 32'h0);

        // Small instance: base 0x1000, four words
        req(1, 1, 1, 32'h100C, 32'hCAFEF00D, SIZE_W, got);
        chk("s.st_cnt", s_st_cnt, 32'd1);
        chk("s.st_err", {31'd0, s_err_v}, 32'd0);
        req(1, 1, 0, 32'h100C, 32'h0, SIZE_W, got);
        chk("s.last_word", got, 32'hCAFEF00D);
        chk("s.ld_cnt", s_ld_cnt, 32'd1);
        req(1, 1, 0, 32'h1010, 32'h0, SIZE_W, got);
        chk("s.above.load", got, 32'h0);
        chk("s.above.err_v", {31'd0, s_err_v}, 32'd1);
        chk("s.above.cause", {30'd0, s_err_cause}, {30'd0, MEM_ERR_RANGE});
        chk("s.above.adr", s_err_adr, 32'h1010);
        req(1, 1, 0, 32'h0FFC, 32'h0, SIZE_W, got);
        chk("s.below.load", got, 32'h0);
        chk("s.below.err_v", {31'd0, s_err_v}, 32'd1);
        chk("s.below.cause", {30'd0, s_err_cause}, {30'd0, MEM_ERR_RANGE});
        chk("s.below.adr", s_err_adr, 32'h0FFC);
        req(1, 0, 0, 32'h100C, 32'h0, SIZE_W, got);
        chk("s.idle.load", got, 32'h0);
        chk("s.idle.err_v", {31'd0, s_err_v}, 32'd0);
        chk("s.idle.cause", {30'd0, s_err_cause}, {30'd0, MEM_ERR_RANGE});
        chk("s.idle.adr", s_err_adr, 32'h0FFC);
        req(1, 1, 0, 32'h0FFD, 32'h0, SIZE_W, got);
        chk("s.prio.cause", {30'd0, s_err_cause}, {30'd0, MEM_ERR_MISAL});
        chk("s.prio.adr", s_err_adr, 32'h0FFD);
        req(1, 1, 0, 32'h100F, 32'h0, SIZE_B, got);
        chk("s.byte.load", got, 32'h000000CA);
        chk("s.byte.err_v", {31'd0, s_err_v}, 32'd0);
        chk("s.final.ld_cnt", s_ld_cnt, 32'd2);
        chk("s.final.st_cnt", s_st_cnt, 32'd1);

        // Randomized traffic: fill a 64-byte window, then mix accesses
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            req(0, 1, 1, 32'(4 * w), d, SIZE_W, got);
            model_step(1, 1, 32'(4 * w), d, SIZE_W, exp);
        end
        check_big_regs("fill");
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 9) != 0);
            st = $urandom_range(0, 1) == 1;
            d  = $urandom;
            r  = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 63));
            else if (r == 8) a = 32'h1000 + 32'($urandom_range(0, 255));
            else             a = $urandom | 32'h8000_0000;
            r  = $urandom_range(0, 7);
            case (r)
                0, 1:    sz = SIZE_B;
                2, 3:    sz = SIZE_H;
                4, 5:    sz = SIZE_W;
                6:       sz = 3'b000;
                default: sz = 3'($urandom_range(0, 7));
            endcase
            req(0, v, st, a, d, sz, got);
            model_step(v, st, a, d, sz, exp);
            if (!(v && st)) chk($sformatf("rnd%0d.load a=%08h sz=%0d", n, a, sz), got, exp);
            check_big_regs($sformatf("rnd%0d", n));
        end

        // Asynchronous reset between edges clears registers at once
        req(0, 1, 0, 32'h11, 32'h0, SIZE_W, got);
        model_step(1, 0, 32'h11, 32'h0, SIZE_W, exp);
        check_big_regs("prerst");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_big_regs("asyncrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        req(0, 1, 0, 32'h10, 32'h0, SIZE_W, got);
        model_step(1, 0, 32'h10, 32'h0, SIZE_W, exp);
        chk("postrst.load", got, exp);
        check_big_regs("postrst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
